sram_line_fetcher: RTL and testbench

//  SRAM read side of the frame buffer that Main writes. It copies one framebuffer row from the

---
 rtl/sram_line_fetcher_pkg.sv | 28 ++
 rtl/sram_line_fetcher_line_buffer_2bank.sv | 53 +++++
 rtl/sram_line_fetcher.sv | 163 ++++++++++++++++
 tb/tb_sram_line_fetcher.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_line_fetcher_pkg.sv
// Shared SRAM frame-buffer definitions, used by the line fetcher, the SRAM
// writer and Main.
//   SRAM_ADDR_W / SRAM_DATA_W : external SRAM word-address and data widths
//   ROW_W / X_W               : widths of the row index and the line-buffer index
//   fetch_state_t             : line-fetcher FSM states
package sram_line_fetcher_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;
    localparam int ROW_W       = 10;
    localparam int X_W         = 10;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } fetch_state_t;

    // Row indices past the bottom of the framebuffer are pinned to the last row.
    function automatic logic [ROW_W-1:0] clampRow(input logic [ROW_W-1:0] row,
                                                  input int unsigned vRows);
        if ({1'b0, row} >= (ROW_W+1)'(vRows)) begin
            return ROW_W'(vRows - 1);
        end
        return row;
    endfunction

endpackage

// File: rtl/sram_line_fetcher_line_buffer_2bank.sv
// Ping-pong line buffer: two banks of DEPTH x 16-bit words in one simple
// dual-port RAM. The write port always targets the back bank (~bankSel_i), the
// registered read port always reads the front bank (bankSel_i).
//   clk_i     : clock
//   rst_ni    : async active-low reset (read register only; RAM contents undefined)
//   bankSel_i : front-bank select
//   wrEn_i    : write enable for the back bank
//   wrAddr_i  : back-bank word index (always < DEPTH)
//   wrData_i  : back-bank write data
//   rdAddr_i  : front-bank word index; indices >= DEPTH read as zero
//   rdData_o  : front-bank word, one clock after rdAddr_i
module sram_line_fetcher_line_buffer_2bank
    import sram_line_fetcher_pkg::*;
#(
    parameter int DEPTH = 640
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   bankSel_i,
    input  logic                   wrEn_i,
    input  logic [X_W-1:0]         wrAddr_i,
    input  logic [SRAM_DATA_W-1:0] wrData_i,
    input  logic [X_W-1:0]         rdAddr_i,
    output logic [SRAM_DATA_W-1:0] rdData_o
);

    logic [SRAM_DATA_W-1:0] mem [0:1][0:DEPTH-1];
    logic [SRAM_DATA_W-1:0] rdData_q;
    logic                   rdInRange;

    assign rdInRange = ({1'b0, rdAddr_i} < (X_W+1)'(DEPTH));

    // Back-bank write port; the RAM itself has no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem[~bankSel_i][wrAddr_i] <= wrData_i;
        end
    end

    // Front-bank registered read; out-of-range indices return zero instead of RAM data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdData_q <= '0;
        end else if (rdInRange) begin
            rdData_q <= mem[bankSel_i][rdAddr_i];
        end else begin
            rdData_q <= '0;
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/sram_line_fetcher.sv
// Copies one framebuffer row from the external 16-bit SRAM into the back bank
// of a ping-pong line buffer, while the VGA pixel path reads the front bank.
//   i_clk, i_rst_n      : pixel clock, async active-low reset
//   i_fetch_start/row   : start pulse and row index of a fetch
//   i_swap              : hsync pulse, exchanges front and back banks when idle
//   i_sram_grant        : arbiter grant for this cycle
//   o_sram_req          : fetch in progress (bus request)
//   o_SRAM_ADDR         : SRAM word address
//   i_SRAM_DQ           : SRAM read data
//   o_SRAM_WE_N         : tied high, this block only reads
//   i_rd_x / o_rd_data  : front-bank read index and registered data
//   o_busy              : fetch in progress
//   o_fetch_done        : one-cycle pulse when the back bank is complete
//   o_underrun          : one-cycle pulse when a swap was refused
module sram_line_fetcher
    import sram_line_fetcher_pkg::*;
#(
    parameter int          H_WORDS     = 640,
    parameter int          V_ROWS      = 512,
    parameter int          READ_CYCLES = 2,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_fetch_start,
    input  logic [ROW_W-1:0]       i_fetch_row,
    input  logic                   i_swap,
    input  logic                   i_sram_grant,
    output logic                   o_sram_req,
    output logic [SRAM_ADDR_W-1:0] o_SRAM_ADDR,
    input  logic [SRAM_DATA_W-1:0] i_SRAM_DQ,
    output logic                   o_SRAM_WE_N,
    input  logic [X_W-1:0]         i_rd_x,
    output logic [SRAM_DATA_W-1:0] o_rd_data,
    output logic                   o_busy,
    output logic                   o_fetch_done,
    output logic                   o_underrun
);

    localparam int                WAIT_W    = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_CYCLES - 1);
    localparam logic [X_W-1:0]    LAST_WORD = X_W'(H_WORDS - 1);

    fetch_state_t           state_q,    state_d;
    logic [SRAM_ADDR_W-1:0] rowAddr_q,  rowAddr_d;
    logic [SRAM_ADDR_W-1:0] sramAddr_q, sramAddr_d;
    logic [X_W-1:0]         wordIdx_q,  wordIdx_d;
    logic [WAIT_W-1:0]      waitCnt_q,  waitCnt_d;
    logic                   bankSel_q,  bankSel_d;
    logic                   underrun_q, underrun_d;
    logic                   capture;
    logic                   fetching;
    logic [SRAM_ADDR_W-1:0] startAddr;

    // Row base address; the multiply is only needed at the start of a fetch.
    assign startAddr = SRAM_ADDR_W'(BASE_ADDR)
                     + SRAM_ADDR_W'(clampRow(i_fetch_row, V_ROWS)) * SRAM_ADDR_W'(H_WORDS);

    // DONE already counts as not busy, so busy/req fall in the cycle the done pulse rises
    // and an hsync landing in DONE is accepted.
    assign fetching = (state_q == READ);

    // Next-state logic: a word is captured only after READ_CYCLES back-to-back granted
    // cycles; a dropped grant restarts the count for the same word.
    always_comb begin
        state_d    = state_q;
        rowAddr_d  = rowAddr_q;
        sramAddr_d = sramAddr_q;
        wordIdx_d  = wordIdx_q;
        waitCnt_d  = waitCnt_q;
        bankSel_d  = bankSel_q;
        underrun_d = 1'b0;
        capture    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_fetch_start) begin
                    state_d    = READ;
                    rowAddr_d  = startAddr;
                    sramAddr_d = startAddr;
                    wordIdx_d  = '0;
                    waitCnt_d  = '0;
                end
            end
            READ: begin
                if (i_sram_grant) begin
                    if (waitCnt_q == WAIT_LAST) begin
                        capture   = 1'b1;
                        waitCnt_d = '0;
                        if (wordIdx_q == LAST_WORD) begin
                            state_d = DONE;
                        end else begin
                            wordIdx_d  = wordIdx_q + 1'b1;
                            sramAddr_d = rowAddr_q + SRAM_ADDR_W'(wordIdx_q) + 20'd1;
                        end
                    end else begin
                        waitCnt_d = waitCnt_q + 1'b1;
                    end
                end else begin
                    waitCnt_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A swap during a fetch, or together with a new start, would expose a
        // half-written bank, so it is refused and flagged instead.
        if (i_swap) begin
            if (fetching || i_fetch_start) begin
                underrun_d = 1'b1;
            end else begin
                bankSel_d = ~bankSel_q;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            rowAddr_q  <= '0;
            sramAddr_q <= '0;
            wordIdx_q  <= '0;
            waitCnt_q  <= '0;
            bankSel_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rowAddr_q  <= rowAddr_d;
            sramAddr_q <= sramAddr_d;
            wordIdx_q  <= wordIdx_d;
            waitCnt_q  <= waitCnt_d;
            bankSel_q  <= bankSel_d;
            underrun_q <= underrun_d;
        end
    end

    sram_line_fetcher_line_buffer_2bank #(
        .DEPTH (H_WORDS)
    ) u_lineBuffer (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .bankSel_i (bankSel_q),
        .wrEn_i    (capture),
        .wrAddr_i  (wordIdx_q),
        .wrData_i  (i_SRAM_DQ),
        .rdAddr_i  (i_rd_x),
        .rdData_o  (o_rd_data)
    );

    assign o_sram_req   = fetching;
    assign o_busy       = fetching;
    assign o_fetch_done = (state_q == DONE);
    assign o_SRAM_ADDR  = sramAddr_q;
    assign o_SRAM_WE_N  = 1'b1;
    assign o_underrun   = underrun_q;

endmodule

// File: tb/tb_sram_line_fetcher.sv
// Directed testbench for sram_line_fetcher (H_WORDS=640, V_ROWS=512, READ_CYCLES=2).
// The SRAM model returns addr[15:0] one clock after a granted address, and 16'hDEAD
// after an ungranted cycle. Inputs change on the falling edge; outputs are sampled there.
module tb_sram_line_fetcher;

    localparam int LIMIT = 5000;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [9:0]  row;
    logic        swap;
    logic        grant;
    logic        sramReq;
    logic [19:0] sramAddr;
    logic [15:0] sramDq;
    logic        weN;
    logic [9:0]  rdX;
    logic [15:0] rdData;
    logic        busy;
    logic        done;
    logic        underrun;

    int compared   = 0;
    int mismatched = 0;
    int grantMode  = 0;
    int grantPhase = 0;

    sram_line_fetcher #(
        .H_WORDS     (640),
        .V_ROWS      (512),
        .READ_CYCLES (2),
        .BASE_ADDR   (0)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_fetch_start (start),
        .i_fetch_row   (row),
        .i_swap        (swap),
        .i_sram_grant  (grant),
        .o_sram_req    (sramReq),
        .o_SRAM_ADDR   (sramAddr),
        .i_SRAM_DQ     (sramDq),
        .o_SRAM_WE_N   (weN),
        .i_rd_x        (rdX),
        .o_rd_data     (rdData),
        .o_busy        (busy),
        .o_fetch_done  (done),
        .o_underrun    (underrun)
    );

    always #5 clk = ~clk;

    // SRAM with one clock of read latency; the bus holds junk after ungranted cycles.
    always @(posedge clk) begin
        sramDq <= grant ? sramAddr[15:0] : 16'hDEAD;
    end

    // Arbiter: grant held, or granted two cycles out of every three.
    initial begin
        grant = 1'b1;
        forever begin
            @(negedge clk);
            if (grantMode == 1) begin
                grantPhase = (grantPhase + 1) % 3;
                grant = (grantPhase != 2);
            end else begin
                grant = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input logic [9:0] r);
        @(negedge clk);
        start = 1'b1;
        row   = r;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulseSwap();
        @(negedge clk);
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
    endtask

    task automatic readAt(input logic [9:0] x, output logic [15:0] d);
        @(negedge clk);
        rdX = x;
        @(negedge clk);
        d = rdData;
    endtask

    // Called in cycle 1 of a fetch; returns the cycle number in which done is seen.
    task automatic waitDone(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rstN  = 1'b0;
        start = 1'b0;
        row   = '0;
        swap  = 1'b0;
        rdX   = '0;
        #12;
        compared++;
        if (busy !== 1'b0 || sramReq !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_busy got busy=%b req=%b want 0 0", busy, sramReq);
        end
        compared++;
        if (done !== 1'b0 || underrun !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_pulses got done=%b underrun=%b want 0 0", done, underrun);
        end
        compared++;
        if (weN !== 1'b1 || rdData !== 16'h0000 || sramAddr !== 20'h00000) begin
            mismatched++;
            $display("[TB] FAIL reset_values got we_n=%b rd=%h addr=%h want 1 0000 00000",
                     weN, rdData, sramAddr);
        end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_basic_fetch();
        int cyc;
        logic [15:0] d;
        applyStimulus(10'd3);
        compared++;
        if (busy !== 1'b1 || sramReq !== 1'b1 || sramAddr !== 20'd1920) begin
            mismatched++;
            $display("[TB] FAIL fetch_begin got busy=%b req=%b addr=%0d want 1 1 1920",
                     busy, sramReq, sramAddr);
        end
        waitDone(cyc);
        compared++;
        if (done !== 1'b1 || cyc != 1281) begin
            mismatched++;
            $display("[TB] FAIL done_latency got done=%b cycle=%0d want 1 1281", done, cyc);
        end
        compared++;
        if (busy !== 1'b0 || sramReq !== 1'b0 || sramAddr !== 20'd2559) begin
            mismatched++;
            $display("[TB] FAIL done_cycle got busy=%b req=%b addr=%0d want 0 0 2559",
                     busy, sramReq, sramAddr);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL done_width got done=%b want 0", done);
        end
        pulseSwap();
        for (int x = 0; x < 640; x++) begin
            readAt(10'(x), d);
            compared++;
            if (d !== 16'(1920 + x)) begin
                mismatched++;
                $display("[TB] FAIL row3_word x=%0d got %h want %h", x, d, 16'(1920 + x));
            end
        end
    endtask

    task automatic test_ping_pong();
        int cyc;
        logic [15:0] d;
        int xs[3] = '{0, 100, 639};
        applyStimulus(10'd5);
        waitDone(cyc);
        compared++;
        if (done !== 1'b1 || cyc != 1281) begin
            mismatched++;
            $display("[TB] FAIL row5_done got done=%b cycle=%0d want 1 1281", done, cyc);
        end
        pulseSwap();
        applyStimulus(10'd6);
        foreach (xs[i]) begin
            readAt(10'(xs[i]), d);
            compared++;
            if (d !== 16'(3200 + xs[i])) begin
                mismatched++;
                $display("[TB] FAIL pp_front_during_fetch x=%0d got %h want %h",
                         xs[i], d, 16'(3200 + xs[i]));
            end
        end
        waitDone(cyc);
        compared++;
        if (done !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL row6_done got done=%b cycle=%0d want 1", done, cyc);
        end
        readAt(10'd1, d);
        compared++;
        if (d !== 16'd3201) begin
            mismatched++;
            $display("[TB] FAIL pp_before_swap got %h want %h", d, 16'd3201);
        end
        pulseSwap();
        foreach (xs[i]) begin
            readAt(10'(xs[i]), d);
            compared++;
            if (d !== 16'(3840 + xs[i])) begin
                mismatched++;
                $display("[TB] FAIL pp_after_swap x=%0d got %h want %h",
                         xs[i], d, 16'(3840 + xs[i]));
            end
        end
    endtask

    task automatic test_grant_toggle();
        int cyc;
        logic [15:0] d;
        grantMode = 1;
        applyStimulus(10'd7);
        waitDone(cyc);
        compared++;
        if (done !== 1'b1 || cyc <= 1281) begin
            mismatched++;
            $display("[TB] FAIL grant_done got done=%b cycle=%0d want 1 after 1281", done, cyc);
        end
        grantMode = 0;
        pulseSwap();
        for (int x = 0; x < 640; x++) begin
            readAt(10'(x), d);
            compared++;
            if (d !== 16'(4480 + x)) begin
                mismatched++;
                $display("[TB] FAIL grant_word x=%0d got %h want %h", x, d, 16'(4480 + x));
            end
        end
    endtask

    task automatic test_underrun();
        int cyc;
        int pulses;
        logic [15:0] d;
        pulses = 0;
        applyStimulus(10'd9);
        rdX = 10'd10;
        cyc = 1;
        while (done !== 1'b1 && cyc < LIMIT) begin
            if (underrun === 1'b1) pulses++;
            if (cyc == 150) begin
                compared++;
                if (rdData !== 16'd4490) begin
                    mismatched++;
                    $display("[TB] FAIL underrun_front got %h want %h", rdData, 16'd4490);
                end
            end
            @(negedge clk);
            cyc++;
            swap  = (cyc == 100);
            start = (cyc == 110);
            row   = 10'd20;
        end
        swap  = 1'b0;
        start = 1'b0;
        compared++;
        if (pulses != 1) begin
            mismatched++;
            $display("[TB] FAIL underrun_pulses got %0d want 1", pulses);
        end
        compared++;
        if (done !== 1'b1 || cyc != 1281) begin
            mismatched++;
            $display("[TB] FAIL restart_ignored got done=%b cycle=%0d want 1 1281", done, cyc);
        end
        pulseSwap();
        readAt(10'd10, d);
        compared++;
        if (d !== 16'd5770) begin
            mismatched++;
            $display("[TB] FAIL row9_word got %h want %h", d, 16'd5770);
        end
        readAt(10'd639, d);
        compared++;
        if (d !== 16'd6399) begin
            mismatched++;
            $display("[TB] FAIL row9_last got %h want %h", d, 16'd6399);
        end
    endtask

    task automatic test_clamp();
        int cyc;
        logic [15:0] d;
        @(negedge clk);
        start = 1'b1;
        row   = 10'd700;
        swap  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        swap  = 1'b0;
        compared++;
        if (underrun !== 1'b1 || sramAddr !== 20'd327040) begin
            mismatched++;
            $display("[TB] FAIL clamp_start got underrun=%b addr=%0d want 1 327040",
                     underrun, sramAddr);
        end
        waitDone(cyc);
        compared++;
        if (done !== 1'b1 || cyc != 1281 || sramAddr !== 20'd327679) begin
            mismatched++;
            $display("[TB] FAIL clamp_done got done=%b cycle=%0d addr=%0d want 1 1281 327679",
                     done, cyc, sramAddr);
        end
        pulseSwap();
        readAt(10'd0, d);
        compared++;
        if (d !== 16'hFD80) begin
            mismatched++;
            $display("[TB] FAIL row511_first got %h want fd80", d);
        end
        readAt(10'd639, d);
        compared++;
        if (d !== 16'hFFFF) begin
            mismatched++;
            $display("[TB] FAIL row511_last got %h want ffff", d);
        end
        readAt(10'd640, d);
        compared++;
        if (d !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL rd_out_of_range got %h want 0000", d);
        end
    endtask

    task automatic test_reset_midfetch();
        int cyc;
        int donePulses;
        logic [15:0] d;
        donePulses = 0;
        applyStimulus(10'd2);
        repeat (601) @(negedge clk);
        rstN = 1'b0;
        #1;
        compared++;
        if (busy !== 1'b0 || sramReq !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset got busy=%b req=%b want 0 0", busy, sramReq);
        end
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) donePulses++;
        end
        rstN = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) donePulses++;
        end
        compared++;
        if (donePulses != 0) begin
            mismatched++;
            $display("[TB] FAIL reset_no_done got %0d pulses want 0", donePulses);
        end
        applyStimulus(10'd4);
        waitDone(cyc);
        compared++;
        if (done !== 1'b1 || cyc != 1281) begin
            mismatched++;
            $display("[TB] FAIL refetch_done got done=%b cycle=%0d want 1 1281", done, cyc);
        end
        pulseSwap();
        readAt(10'd5, d);
        compared++;
        if (d !== 16'd2565) begin
            mismatched++;
            $display("[TB] FAIL row4_word got %h want %h", d, 16'd2565);
        end
        readAt(10'd639, d);
        compared++;
        if (d !== 16'd3199) begin
            mismatched++;
            $display("[TB] FAIL row4_last got %h want %h", d, 16'd3199);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_ping_pong();
        test_grant_toggle();
        test_underrun();
        test_clamp();
        test_reset_midfetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
